// File: rtl/fetch_stage.sv
// fetch_stage: PC, byte-wide instruction fetch and IF/ID register for one- and two-byte instructions
module fetch_stage #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [3:0] LONG_OP = 4'd12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              if_id_en,
  input  logic              flush,
  input  logic              bt,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        if_id_instr,
  output logic [7:0]        if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc_next,
  output logic              if_id_valid
);
  typedef enum logic {S_FETCH1, S_FETCH2} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic [7:0] hold, ld_instr, ld_imm;
  logic is_long, ld_valid;
  assign imem_addr = pc;
  always_comb begin
    pc_inc = pc + 1'b1;
    is_long = imem_rdata[7:4] == LONG_OP;
    ld_instr = state == S_FETCH2 ? hold : imem_rdata;
    ld_imm = state == S_FETCH2 ? imem_rdata : 8'h00;
    ld_valid = pc_en && (state == S_FETCH2 || !is_long);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
      state <= S_FETCH1;
      hold <= 8'h00;
      if_id_instr <= 8'h00;
      if_id_imm <= 8'h00;
      if_id_pc_next <= '0;
      if_id_valid <= 1'b0;
    end else begin
      if (bt) begin
        pc <= branch_target;
        state <= S_FETCH1;
        hold <= 8'h00;
      end else if (pc_en) begin
        pc <= pc_inc;
        state <= (state == S_FETCH1 && is_long) ? S_FETCH2 : S_FETCH1;
        if (state == S_FETCH1 && is_long) hold <= imem_rdata;
      end
      // A loading edge with nothing complete to hand over becomes a bubble
      if (bt || flush || (if_id_en && !ld_valid)) begin
        if_id_instr <= 8'h00;
        if_id_imm <= 8'h00;
        if_id_valid <= 1'b0;
      end else if (if_id_en) begin
        if_id_instr <= ld_instr;
        if_id_imm <= ld_imm;
        if_id_pc_next <= pc_inc;
        if_id_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random fetch stimulus checked against a byte-queue reference model
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, pc_en = 1'b0, if_id_en = 1'b0, flush = 1'b0, bt = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic [7:0] imem_addr, imem_rdata, if_id_instr, if_id_imm, if_id_pc_next;
  logic if_id_valid;
  logic [7:0] mem [256];
  int checks = 0, errors = 0;
  logic [7:0] m_pc, m_instr, m_imm, m_pcn;
  logic m_valid;
  logic [7:0] pend [$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .if_id_en(if_id_en), .flush(flush), .bt(bt),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_imm(if_id_imm), .if_id_pc_next(if_id_pc_next),
    .if_id_valid(if_id_valid)
  );

  assign imem_rdata = mem[imem_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The model collects fetched bytes until a whole instruction is present, then hands it over
  task automatic step(input logic r, input logic pe, input logic ie, input logic fl,
                      input logic b, input logic [7:0] tg);
    logic emit;
    logic [7:0] ei, em;
    rst = r; pc_en = pe; if_id_en = ie; flush = fl; bt = b; branch_target = tg;
    emit = 1'b0; ei = 8'h00; em = 8'h00;
    if (r) begin
      m_pc = 8'h00; pend.delete();
      m_instr = 8'h00; m_imm = 8'h00; m_pcn = 8'h00; m_valid = 1'b0;
    end else begin
      if (b) begin
        pend.delete();
        m_pc = tg;
      end else if (pe) begin
        pend.push_back(mem[m_pc]);
        m_pc = m_pc + 8'd1;
        if (pend[0][7:4] != 4'd12 || pend.size() == 2) begin
          emit = 1'b1;
          ei = pend[0];
          em = pend.size() == 2 ? pend[1] : 8'h00;
          pend.delete();
        end
      end
      if (b || fl || (ie && !emit)) begin
        m_instr = 8'h00; m_imm = 8'h00; m_valid = 1'b0;
      end else if (ie) begin
        m_instr = ei; m_imm = em; m_pcn = m_pc; m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_valid", {7'b0, if_id_valid}, {7'b0, m_valid});
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_imm", if_id_imm, m_imm);
    if (m_valid) chk("if_id_pc_next", if_id_pc_next, m_pcn);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    // reset and one-byte stream
    mem[0] = 8'h21; mem[1] = 8'h35; mem[2] = 8'h4A;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset_addr", imem_addr, 8'h00);
    chk("reset_instr", if_id_instr, 8'h00);
    run(1);
    chk("stream0", if_id_instr, 8'h21);
    run(1);
    chk("stream1", if_id_instr, 8'h35);
    run(1);
    chk("stream2", if_id_instr, 8'h4A);
    chk("stream2_pcn", if_id_pc_next, 8'h03);
    // two-byte instruction
    mem[0] = 8'hC1; mem[1] = 8'h7F;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run(1);
    chk("long_bubble", {7'b0, if_id_valid}, 8'h00);
    run(1);
    chk("long_instr", if_id_instr, 8'hC1);
    chk("long_imm", if_id_imm, 8'h7F);
    chk("long_pcn", if_id_pc_next, 8'h02);
    // stall mid-stream at pc 05
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run(5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stall_pc", imem_addr, 8'h05);
    chk("stall_instr", if_id_instr, 8'h05);
    run(1);
    chk("stall_resume", if_id_instr, 8'h06);
    // branch while half-way through a two-byte instruction
    mem[8'h10] = 8'hC1; mem[8'h11] = 8'h55; mem[8'h40] = 8'h01;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
    run(1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40);
    chk("branch_pc", imem_addr, 8'h40);
    chk("branch_bubble", {7'b0, if_id_valid}, 8'h00);
    run(1);
    chk("branch_instr", if_id_instr, 8'h01);
    // two-byte instruction wrapping past FF
    mem[8'hFF] = 8'hC2; mem[8'h00] = 8'h09;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
    run(2);
    chk("wrap_instr", if_id_instr, 8'hC2);
    chk("wrap_imm", if_id_imm, 8'h09);
    chk("wrap_pcn", if_id_pc_next, 8'h01);
    chk("wrap_pc", imem_addr, 8'h01);
    // random phase with a generous share of two-byte opcodes
    for (int i = 0; i < 256; i++) mem[i] = ($urandom % 3 == 0) ? {4'hC, 4'($urandom)} : 8'($urandom);
    for (int i = 0; i < 3000; i++)
      step($urandom % 64 == 0, $urandom % 4 != 0, $urandom % 5 != 0, $urandom % 8 == 0,
           $urandom % 10 == 0, 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 8-bit pipelined processor.
- Owns the PC and reads byte-wide instruction memory.
- Assembles one- and two-byte instructions and presents them to decode.
- Obeys the hazard unit's pc_en / if_id_en / flush and the branch-taken redirect (bt, branch_target).

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- RESET_VEC, 8'h00, PC value after reset.
- LONG_OP, 4'd12, opcode (instr[7:4]) marking a two-byte instruction; the second byte is the immediate/address.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- pc_en  input  1  1 = PC/FSM may advance; 0 = freeze (hazard stall)
- if_id_en  input  1  1 = IF/ID register may load; 0 = hold
- flush  input  1  1 = IF/ID loads a bubble on this edge
- bt  input  1  branch taken; redirect PC this edge
- branch_target  input  ADDR_W  redirect address, valid when bt=1
- imem_addr  output  ADDR_W  instruction-memory address (combinational = pc)
- imem_rdata  input  8  instruction byte, asynchronous read, valid same cycle
- if_id_instr  output  8  first instruction byte to decode
- if_id_imm  output  8  second byte of a two-byte instruction, else 8'h00
- if_id_pc_next  output  ADDR_W  address following the instruction (for call/return)
- if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble

Behaviour:
- Reset (rst=1 at edge): pc=RESET_VEC, state=S_FETCH1, hold=8'h00. if_id_instr=8'h00 (NOP), if_id_imm=8'h00, if_id_pc_next=0, if_id_valid=0. rst overrides every other input.
- imem_addr = pc combinationally at all times.
- FSM states: S_FETCH1 (first byte), S_FETCH2 (immediate byte). The FSM, pc and hold update only on edges with pc_en=1, unless bt=1.
- S_FETCH1, pc_en=1, imem_rdata[7:4]!=LONG_OP:
  - pc<=pc+1; stay in S_FETCH1.
  - IF/ID (if if_id_en): instr<=rdata, imm<=0, pc_next<=pc+1, valid<=1.
- S_FETCH1, pc_en=1, opcode==LONG_OP:
  - hold<=rdata, pc<=pc+1, state<=S_FETCH2.
  - IF/ID (if if_id_en) loads a bubble (instr=0, imm=0, valid=0).
- S_FETCH2, pc_en=1:
  - pc<=pc+1, state<=S_FETCH1.
  - IF/ID (if if_id_en): instr<=hold, imm<=rdata, pc_next<=pc+1, valid<=1.
- pc_en=0: pc, state and hold frozen. If if_id_en=1 in the same cycle, IF/ID loads a bubble. If if_id_en=0, IF/ID holds all fields.
- Flush: flush=1 forces an IF/ID bubble, overriding if_id_en and any load. pc/FSM still follow the rules above.
- Redirect: bt=1 forces pc<=branch_target, state<=S_FETCH1, hold<=0. This holds regardless of pc_en or state, so a half-fetched two-byte instruction is discarded. IF/ID loads a bubble on the same edge even if flush=0.
- Priority: rst > bt > flush > pc_en/if_id_en.
- Arithmetic: pc+1 is modulo 2^ADDR_W; 8'hFF wraps to 8'h00. A two-byte instruction at 8'hFF takes its immediate from 8'h00, with pc_next=8'h01.
- Latency: a one-byte instruction at address A is in IF/ID one edge after pc=A. A two-byte instruction is in IF/ID two edges after pc=A, preceded by one bubble.
- No combinational path from inputs to IF/ID outputs.

Test Plan:
- Reset: rst=1 for 2 cycles, RESET_VEC=8'h00 -> imem_addr=00, if_id_valid=0, if_id_instr=00. Release -> pc advances 00,01,02.
- One-byte stream: mem[00..02]=8'h21,8'h35,8'h4A, all enables 1 -> IF/ID shows 21/35/4A on consecutive edges, pc_next 01/02/03, valid=1.
- Two-byte: mem[00]=8'hC1, mem[01]=8'h7F -> edge1 bubble; edge2 instr=C1, imm=7F, pc_next=02, valid=1.
- Stall: pc_en=0, if_id_en=0 for 3 cycles mid-stream at pc=05 -> pc stays 05, IF/ID unchanged. Release -> continues with mem[05].
- Branch in S_FETCH2: after first byte C1 at 10, bt=1 with target 8'h40 -> pc=40, state S_FETCH1, IF/ID bubble, C1 never reaches decode.
- Wrap: mem[FF]=8'hC2, mem[00]=8'h09, pc=FF -> instr=C2, imm=09, pc_next=01, pc=01.
